// File: rtl/wallace_csa_reducer.sv
// Iterative 16x16 carry-save multiplier core: compresses ROWS_PER_CYCLE partial-product rows per cycle into sum/carry words.
// Define WALLACE_SIGNED_EN for two's-complement operands (Baugh-Wooley rows plus correction constant).
module wallace_csa_reducer #(
  parameter int unsigned ROWS_PER_CYCLE = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] sum_vec,
  output logic [31:0] carry_vec
);

  localparam int unsigned OP_W     = 16;
  localparam int unsigned PROD_W   = 32;
  localparam int unsigned CNT_W    = 5;
  localparam int unsigned NUM_IN   = ROWS_PER_CYCLE + 2;
  localparam int unsigned NUM_SLOT = 3 * NUM_IN - 4;
  localparam int unsigned LAST_CNT = OP_W - ROWS_PER_CYCLE;
  localparam int unsigned ROWS_W   = ROWS_PER_CYCLE * PROD_W;

`ifdef WALLACE_SIGNED_EN
  // Sum of the -2^k terms from the inverted cross products, folded mod 2^32
  localparam logic [PROD_W-1:0] BW_CORR = 32'h8001_0000;
`endif

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REDUCE = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      row_cnt_q, row_cnt_d;
  logic [OP_W-1:0]       a_q, a_d, b_q, b_d;
  logic [PROD_W-1:0]     sum_d, carry_d;
  logic                  in_ready_d, out_valid_d;

  logic [ROWS_W-1:0]     rows;
  logic [PROD_W-1:0]     carry_seed;
  logic [PROD_W-1:0]     red_sum, red_carry;

  // One partial-product row, shifted into place
  function automatic logic [PROD_W-1:0] pp_row(input logic [OP_W-1:0] av,
                                               input logic [OP_W-1:0] bv,
                                               input logic [3:0]      idx);
    logic [OP_W-1:0] p;
    p = bv[idx] ? av : '0;
`ifdef WALLACE_SIGNED_EN
    if (idx == 4'd15) p[OP_W-2:0] = ~p[OP_W-2:0];
    else              p[OP_W-1]   = ~p[OP_W-1];
`endif
    return PROD_W'(p) << idx;
  endfunction

  // 3:2 compressor tree: each adder consumes the three oldest words and appends two
  function automatic logic [2*PROD_W-1:0] csa_reduce(input logic [PROD_W-1:0] s_in,
                                                     input logic [PROD_W-1:0] c_in,
                                                     input logic [ROWS_W-1:0] rv);
    logic [PROD_W-1:0] slot [NUM_SLOT];
    logic [PROD_W-1:0] x, y, z;
    for (int i = 0; i < int'(NUM_SLOT); i++) slot[i] = '0;
    slot[0] = s_in;
    slot[1] = c_in;
    for (int r = 0; r < int'(ROWS_PER_CYCLE); r++) slot[r+2] = rv[r*PROD_W +: PROD_W];
    for (int j = 0; j < int'(NUM_IN) - 2; j++) begin
      x = slot[3*j];
      y = slot[3*j+1];
      z = slot[3*j+2];
      slot[int'(NUM_IN)+2*j]   = x ^ y ^ z;
      slot[int'(NUM_IN)+2*j+1] = ((x & y) | (x & z) | (y & z)) << 1;
    end
    return {slot[NUM_SLOT-2], slot[NUM_SLOT-1]};
  endfunction

  always_comb begin
    rows = '0;
    for (int r = 0; r < int'(ROWS_PER_CYCLE); r++) begin
      rows[r*PROD_W +: PROD_W] = pp_row(a_q, b_q, 4'(row_cnt_q + CNT_W'(r)));
    end
  end

  // The carry accumulator is zero on the first pass, so that slot carries the correction
`ifdef WALLACE_SIGNED_EN
  assign carry_seed = (row_cnt_q == '0) ? BW_CORR : carry_vec;
`else
  assign carry_seed = carry_vec;
`endif

  assign {red_sum, red_carry} = csa_reduce(sum_vec, carry_seed, rows);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      row_cnt_q <= '0;
      a_q       <= '0;
      b_q       <= '0;
      sum_vec   <= '0;
      carry_vec <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_cnt_q <= row_cnt_d;
      a_q       <= a_d;
      b_q       <= b_d;
      sum_vec   <= sum_d;
      carry_vec <= carry_d;
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    row_cnt_d   = row_cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    sum_d       = sum_vec;
    carry_d     = carry_vec;
    in_ready_d  = 1'b0;
    out_valid_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          a_d       = a;
          b_d       = b;
          sum_d     = '0;
          carry_d   = '0;
          row_cnt_d = '0;
          state_d   = REDUCE;
        end
      end
      REDUCE: begin
        sum_d     = red_sum;
        carry_d   = red_carry;
        row_cnt_d = row_cnt_q + CNT_W'(ROWS_PER_CYCLE);
        if (row_cnt_q == CNT_W'(LAST_CNT)) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

endmodule

// File: tb/tb_wallace_csa_reducer.sv
// Randomized self-checking bench for wallace_csa_reducer, three instances (4, 1 and 16 rows per cycle).
module tb_wallace_csa_reducer;

  localparam int R_MAIN = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic [31:0] sum_vec, carry_vec;

  logic        u1_iv = 1'b0, u1_ir, u1_ov, u1_or = 1'b1;
  logic [15:0] u1_a = '0, u1_b = '0;
  logic [31:0] u1_s, u1_c;
  logic        u16_iv = 1'b0, u16_ir, u16_ov, u16_or = 1'b1;
  logic [15:0] u16_a = '0, u16_b = '0;
  logic [31:0] u16_s, u16_c;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wallace_csa_reducer #(.ROWS_PER_CYCLE(R_MAIN)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .sum_vec(sum_vec), .carry_vec(carry_vec));

  wallace_csa_reducer #(.ROWS_PER_CYCLE(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(u1_iv), .in_ready(u1_ir), .a(u1_a), .b(u1_b),
    .out_valid(u1_ov), .out_ready(u1_or), .sum_vec(u1_s), .carry_vec(u1_c));

  wallace_csa_reducer #(.ROWS_PER_CYCLE(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(u16_iv), .in_ready(u16_ir), .a(u16_a), .b(u16_b),
    .out_valid(u16_ov), .out_ready(u16_or), .sum_vec(u16_s), .carry_vec(u16_c));

  function automatic logic [31:0] ref_mul(input logic [15:0] x, input logic [15:0] y);
`ifdef WALLACE_SIGNED_EN
    int sx, sy;
    sx = $signed(x);
    sy = $signed(y);
    return 32'(sx * sy);
`else
    return 32'(x) * 32'(y);
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  // Transaction-level model of the main instance: fixed latency after accept, hold until out_ready
  logic        m_idle = 1'b1, m_valid = 1'b0, m_zero = 1'b1, m_opzero = 1'b0;
  int          m_left = 0;
  logic [31:0] m_prod = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_idle <= 1'b1; m_valid <= 1'b0; m_zero <= 1'b1; m_left <= 0;
    end else if (m_idle) begin
      if (in_valid) begin
        m_idle   <= 1'b0;
        m_left   <= 16 / R_MAIN;
        m_prod   <= ref_mul(a, b);
        m_opzero <= (a == 16'h0) || (b == 16'h0);
        m_zero   <= 1'b0;
      end
    end else if (m_left != 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) m_valid <= 1'b1;
    end else if (out_ready) begin
      m_valid <= 1'b0;
      m_idle  <= 1'b1;
    end
  end

  always @(negedge clk) begin
    chk("in_ready", 32'(in_ready), 32'(m_idle));
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    if (m_zero) begin
      chk("sum_zero", sum_vec, 32'h0);
      chk("carry_zero", carry_vec, 32'h0);
    end
    if (m_valid) chk("product", sum_vec + carry_vec, m_prod);
`ifndef WALLACE_SIGNED_EN
    if (m_valid && m_opzero) begin
      chk("zero_op_sum", sum_vec, 32'h0);
      chk("zero_op_carry", carry_vec, 32'h0);
    end
`endif
  end

  task automatic send(input logic [15:0] av, input logic [15:0] bv);
    int n = 0;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (!in_ready) chk("send_timeout", 32'(in_ready), 32'h1);
    in_valid = 1'b1; a = av; b = bv;
    @(posedge clk); #1;
    in_valid = 1'b0; a = 16'($urandom); b = 16'($urandom);
  endtask

  task automatic wait_out(input int exp_lat, input bit junk,
                          output logic [31:0] s, output logic [31:0] c);
    int n = 0;
    while (!out_valid && n < 40) begin
      if (junk) begin
        in_valid = 1'($urandom); a = 16'($urandom); b = 16'($urandom);
      end
      @(posedge clk); #1; n++;
    end
    in_valid = 1'b0;
    chk("latency", 32'(n), 32'(exp_lat));
    s = sum_vec;
    c = carry_vec;
  endtask

  task automatic release_out(input int hold);
    repeat (hold) begin @(posedge clk); #1; end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] s, c, hs, hc;
    logic [15:0] ra, rb;
    int n;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'h1);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_sum", sum_vec, 32'h0);
    rst = 1'b0;

    // Small product, minimal hold
    send(16'h0003, 16'h0005);
    wait_out(4, 1'b0, s, c);
    chk("p_3x5", s + c, 32'h0000000F);
    release_out(0);

    // All-ones operands
    send(16'hFFFF, 16'hFFFF);
    wait_out(4, 1'b0, s, c);
`ifdef WALLACE_SIGNED_EN
    chk("p_ffff_sq", s + c, 32'h00000001);
`else
    chk("p_ffff_sq", s + c, 32'hFFFE0001);
`endif
    release_out(0);

    // Backpressure: outputs stable, new operands ignored
    send(16'h1111, 16'h2222);
    wait_out(4, 1'b0, hs, hc);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin in_valid = 1'b1; a = 16'h1234; b = 16'h0042; end
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("hold_sum", sum_vec, hs);
      chk("hold_carry", carry_vec, hc);
      chk("hold_in_ready", 32'(in_ready), 32'h0);
    end
    chk("p_hold", hs + hc, 32'h02468642);
    release_out(0);

    // Zero operand still takes the full latency
    send(16'h0000, 16'h5555);
    wait_out(4, 1'b0, s, c);
    chk("p_zero", s + c, 32'h0);
    release_out(1);

    // Reset during the second reduce cycle
    send(16'h0002, 16'h0003);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("abort_in_ready", 32'(in_ready), 32'h1);
    chk("abort_out_valid", 32'(out_valid), 32'h0);
    chk("abort_sum", sum_vec, 32'h0);
    chk("abort_carry", carry_vec, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    send(16'h0007, 16'h0009);
    wait_out(4, 1'b0, s, c);
    chk("p_7x9", s + c, 32'h0000003F);
    release_out(0);

    // Narrow and full-width per-cycle configurations
    chk("u1_ready", 32'(u1_ir), 32'h1);
    u1_iv = 1'b1; u1_a = 16'hABCD; u1_b = 16'h1234;
    @(posedge clk); #1;
    u1_iv = 1'b0;
    n = 0;
    while (!u1_ov && n < 40) begin @(posedge clk); #1; n++; end
    chk("u1_latency", 32'(n), 32'd16);
`ifdef WALLACE_SIGNED_EN
    chk("u1_prod", u1_s + u1_c, 32'hFA034FA4);
`else
    chk("u1_prod", u1_s + u1_c, 32'h0C374FA4);
`endif
    chk("u16_ready", 32'(u16_ir), 32'h1);
    u16_iv = 1'b1; u16_a = 16'hABCD; u16_b = 16'h1234;
    @(posedge clk); #1;
    u16_iv = 1'b0;
    n = 0;
    while (!u16_ov && n < 40) begin @(posedge clk); #1; n++; end
    chk("u16_latency", 32'(n), 32'd1);
`ifdef WALLACE_SIGNED_EN
    chk("u16_prod", u16_s + u16_c, 32'hFA034FA4);
`else
    chk("u16_prod", u16_s + u16_c, 32'h0C374FA4);
`endif

    // Random back-to-back traffic with junk inputs while busy
    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      if ($urandom_range(0, 15) == 0) ra = 16'h0;
      if ($urandom_range(0, 15) == 0) rb = 16'h0;
      send(ra, rb);
      wait_out(4, 1'b1, s, c);
      chk("rand_prod", s + c, ref_mul(ra, rb));
      release_out($urandom_range(0, 2));
    end

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
